lane_arbiter: RTL and testbench
===============================

LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: max bytes accepted from one lane per grant, legal range 1..15.
REQ-002 Parameter IDLE_SYM, default 8'hBC: value driven on data_out when no byte is presented.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with the ports listed below.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous reset, active-high.
REQ-006 In0, In1, In2, In3  input  8 each  requester data bytes.
REQ-007 valid0, valid1, valid2, valid3  input  1 each  requester byte-valid.
REQ-008 ready0, ready1, ready2, ready3  output  1 each  requester byte-accepted, registered.
REQ-009 ready_in  input  1  downstream (serializer mux) can take data_out this cycle.
REQ-010 data_out  output  8  registered shared-lane byte.
REQ-011 valid_out  output  1  registered qualifier for data_out.
REQ-012 grant  output  2  index of the currently granted lane, registered.
REQ-013 busy  output  1  high while in state BURST.

Function
REQ-014 The FSM SHALL have two states, IDLE and BURST, plus a 2-bit round-robin pointer ptr and a 4-bit burst counter cnt.
REQ-015 Handshake: lane k transfers in a cycle iff validk && readyk; data SHALL be held stable by the requester until it transfers.
REQ-016 Output register free (load_ok) = !valid_out || ready_in.
REQ-017 readyk SHALL be 1 only when state==BURST && grant==k && load_ok, and 0 for every other lane.
REQ-018 In IDLE with any validk high, the block SHALL select the first valid lane searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), load grant, clear cnt, and enter BURST on the next edge. No byte transfers in this cycle.
REQ-019 In IDLE with no valid input, the block SHALL stay in IDLE and leave grant unchanged.
REQ-020 On a transfer in BURST, data_out SHALL take Ink and valid_out SHALL be 1 on the next edge, giving one cycle latency from accept to output.
REQ-021 In BURST on a transfer, cnt SHALL increment. If cnt==BURST_MAX-1, the FSM SHALL go to IDLE and set ptr=grant+1 (mod 4).
REQ-022 In BURST, if load_ok && !valid[grant] (the requester has gone idle), the FSM SHALL go to IDLE with ptr=grant+1 and perform no transfer.
REQ-023 In BURST with load_ok==0 (backpressure), the FSM SHALL hold state, cnt, data_out and valid_out unchanged.
REQ-024 When load_ok && no transfer, the next-edge values SHALL be valid_out=0 and data_out=IDLE_SYM.
REQ-025 Request changes on non-granted lanes SHALL have no effect during BURST.
REQ-026 Minimum re-arbitration gap: one IDLE cycle between bursts, so valid_out is low for at least one cycle between grants when ready_in is held high.
REQ-027 ptr wraps from 3 to 0. With all four lanes continuously valid, the grant order SHALL be 0,1,2,3,0,...

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, cnt=0, grant=0, busy=0, ready0..3=0, valid_out=0, data_out=IDLE_SYM.
REQ-029 Reset asserted mid-burst SHALL abort the burst. The byte held in the output register SHALL be discarded and no ready SHALL be high in the following cycle.
REQ-030 The first grant after reset deassertion SHALL use ptr=0 priority.

Verification
REQ-031 Single lane: valid2=1, In2=8'h11..8'h16, ready_in=1 -> grant=2; bytes 11,12,13,14 appear on data_out; one IDLE cycle with data_out=BC, valid_out=0; then 15,16.
REQ-032 All lanes valid after reset, ready_in=1 -> grants 0,1,2,3,0 in order, 4 bytes each, one idle gap between each burst.
REQ-033 Backpressure: ready_in=0 for 3 cycles mid-burst on lane 1 -> data_out, valid_out and cnt frozen and ready1=0; burst resumes with no byte lost or duplicated.
REQ-034 Early release: lane 3 drops valid after 2 bytes while lane 0 is valid -> FSM returns to IDLE, ptr=0, next grant=0.
REQ-035 Reset pulse on the 2nd byte of a burst -> next cycle all outputs at reset values; first grant after release goes to the lowest valid index.
REQ-036 BURST_MAX=1 with lanes 0 and 1 continuously valid -> output alternates between lane-0 and lane-1 bytes, separated by IDLE_SYM cycles.

Source files
------------

// File: rtl/lane_arbiter.sv
// Round-robin arbiter merging four byte-wide requester lanes onto one registered output lane.
// A lane keeps its grant for up to BURST_MAX bytes. It loses the grant early if it stops presenting data.
module lane_arbiter #(
    parameter int unsigned BURST_MAX = 4,
    parameter logic [7:0]  IDLE_SYM  = 8'hBC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] In0,
    input  logic [7:0] In1,
    input  logic [7:0] In2,
    input  logic [7:0] In3,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       valid2,
    input  logic       valid3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    input  logic       ready_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] grant,
    output logic       busy
);

    // Handshake: lane k moves a byte on a rising edge where validk && readyk are both high.
    // The requester holds Ink stable until that edge.
    // readyk is decoded from registered state plus ready_in. It cannot go high
    // while the output register is still holding an unconsumed byte.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       vout_q, vout_d;

    logic [7:0] lane_data [4];
    logic [3:0] lane_valid;
    logic       load_ok;
    logic       in_burst;
    logic [1:0] cand;
    logic [1:0] pick;
    logic       pick_found;

    always_comb begin
        lane_data[0] = In0;
        lane_data[1] = In1;
        lane_data[2] = In2;
        lane_data[3] = In3;
    end

    assign lane_valid = {valid3, valid2, valid1, valid0};
    assign load_ok    = !vout_q || ready_in;
    assign in_burst   = (state_q == BURST);

    // Scan from the farthest offset down, so the nearest valid lane after ptr wins.
    always_comb begin
        cand       = ptr_q;
        pick       = ptr_q;
        pick_found = 1'b0;
        for (int o = 3; o >= 0; o--) begin
            cand = ptr_q + 2'(o);
            if (lane_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        vout_d  = vout_q;
        // A free output register with nothing loaded into it falls back to the idle symbol.
        if (load_ok) begin
            data_d = IDLE_SYM;
            vout_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    cnt_d   = 4'd0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (load_ok) begin
                    if (lane_valid[grant_q]) begin
                        data_d = lane_data[grant_q];
                        vout_d = 1'b1;
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == LAST_IDX) begin
                            state_d = IDLE;
                            ptr_d   = grant_q + 2'd1;
                        end
                    end else begin
                        state_d = IDLE;
                        ptr_d   = grant_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 2'd0;
            cnt_q   <= 4'd0;
            data_q  <= IDLE_SYM;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vout_q  <= vout_d;
        end
    end

    assign ready0    = in_burst && (grant_q == 2'd0) && load_ok;
    assign ready1    = in_burst && (grant_q == 2'd1) && load_ok;
    assign ready2    = in_burst && (grant_q == 2'd2) && load_ok;
    assign ready3    = in_burst && (grant_q == 2'd3) && load_ok;
    assign data_out  = data_q;
    assign valid_out = vout_q;
    assign grant     = grant_q;
    assign busy      = in_burst;

endmodule

// File: tb/tb_lane_arbiter.sv
// Bench for lane_arbiter. Two instances run side by side: one with the default BURST_MAX of 4, one with BURST_MAX of 1.
// A lane-level reference model and byte-stream scoreboards check each instance.
module tb_lane_arbiter;
  localparam int N = 2;
  localparam logic [7:0] IDLE_SYM = 8'hBC;

  int unsigned bmax [N] = '{4, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din  [N][4];
  logic       vld  [N][4];
  logic       rin  [N];
  logic       rdy  [N][4];
  logic [7:0] dout [N];
  logic       vout [N];
  logic [1:0] gnt  [N];
  logic       bsy  [N];

  int n_checks = 0;
  int n_errors = 0;

  // reference model: per instance, whether a lane owns the output and how many bytes it has taken
  bit         m_busy  [N];
  int         m_grant [N];
  int         m_next  [N];
  int         m_taken [N];
  bit         m_vout  [N];
  logic [7:0] m_dout  [N];
  bit         xfer    [N][4];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] log_q[$];
  logic [1:0] gnt_log[$];
  bit         logging = 1'b0;
  bit         prev_bsy0 = 1'b0;

  always #5 clk = ~clk;

  lane_arbiter #(.BURST_MAX(4), .IDLE_SYM(IDLE_SYM)) dut0 (
    .clk(clk), .reset(reset),
    .In0(din[0][0]), .In1(din[0][1]), .In2(din[0][2]), .In3(din[0][3]),
    .valid0(vld[0][0]), .valid1(vld[0][1]), .valid2(vld[0][2]), .valid3(vld[0][3]),
    .ready0(rdy[0][0]), .ready1(rdy[0][1]), .ready2(rdy[0][2]), .ready3(rdy[0][3]),
    .ready_in(rin[0]), .data_out(dout[0]), .valid_out(vout[0]), .grant(gnt[0]), .busy(bsy[0])
  );

  lane_arbiter #(.BURST_MAX(1), .IDLE_SYM(IDLE_SYM)) dut1 (
    .clk(clk), .reset(reset),
    .In0(din[1][0]), .In1(din[1][1]), .In2(din[1][2]), .In3(din[1][3]),
    .valid0(vld[1][0]), .valid1(vld[1][1]), .valid2(vld[1][2]), .valid3(vld[1][3]),
    .ready0(rdy[1][0]), .ready1(rdy[1][1]), .ready2(rdy[1][2]), .ready3(rdy[1][3]),
    .ready_in(rin[1]), .data_out(dout[1]), .valid_out(vout[1]), .grant(gnt[1]), .busy(bsy[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_busy[i]  = 1'b0;
    m_grant[i] = 0;
    m_next[i]  = 0;
    m_taken[i] = 0;
    m_vout[i]  = 1'b0;
    m_dout[i]  = IDLE_SYM;
    if (i == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  // the first lane found valid when searching from the priority lane onward
  function automatic int first_valid(input int i);
    for (int o = 0; o < 4; o++)
      if (vld[i][(m_next[i] + o) % 4]) return (m_next[i] + o) % 4;
    return -1;
  endfunction

  task automatic model_step(input int i);
    bit room;
    int g;
    room = !m_vout[i] || rin[i];
    if (reset) begin
      model_reset(i);
      return;
    end
    if (!m_busy[i]) begin
      if (room) begin
        m_vout[i] = 1'b0;
        m_dout[i] = IDLE_SYM;
      end
      g = first_valid(i);
      if (g >= 0) begin
        m_busy[i]  = 1'b1;
        m_grant[i] = g;
        m_taken[i] = 0;
      end
    end else if (room) begin
      g = m_grant[i];
      if (vld[i][g]) begin
        m_vout[i] = 1'b1;
        m_dout[i] = din[i][g];
        if (i == 0) exp_q0.push_back(din[i][g]); else exp_q1.push_back(din[i][g]);
        m_taken[i]++;
        if (m_taken[i] == int'(bmax[i])) begin
          m_busy[i] = 1'b0;
          m_next[i] = (g + 1) % 4;
        end
      end else begin
        m_vout[i] = 1'b0;
        m_dout[i] = IDLE_SYM;
        m_busy[i] = 1'b0;
        m_next[i] = (g + 1) % 4;
      end
    end
  endtask

  task automatic sb_pop(input int i);
    logic [7:0] e;
    int sz;
    sz = (i == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      check_eq($sformatf("stream%0d_unexpected_byte", i), 32'(dout[i]), 32'h100);
    end else begin
      e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check_eq($sformatf("stream%0d", i), 32'(dout[i]), 32'(e));
    end
  endtask

  // runs one clock: ready checks before the edge, registered-output checks after it
  task automatic cycle();
    bit er;
    #1;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4; k++) begin
        er = m_busy[i] && (m_grant[i] == k) && (!m_vout[i] || rin[i]);
        check_eq($sformatf("ready%0d_%0d", i, k), 32'(rdy[i][k]), 32'(er));
        xfer[i][k] = vld[i][k] && rdy[i][k];
      end
      if (vout[i] && rin[i]) begin
        if (i == 0 && logging) log_q.push_back(dout[0]);
        sb_pop(i);
      end
      model_step(i);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("data_out%0d", i), 32'(dout[i]), 32'(m_dout[i]));
      check_eq($sformatf("valid_out%0d", i), 32'(vout[i]), 32'(m_vout[i]));
      check_eq($sformatf("grant%0d", i), 32'(gnt[i]), 32'(m_grant[i]));
      check_eq($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_busy[i]));
    end
    if (bsy[0] && !prev_bsy0) gnt_log.push_back(gnt[0]);
    prev_bsy0 = bsy[0];
  endtask

  task automatic drive_idle(input int i);
    for (int k = 0; k < 4; k++) begin
      vld[i][k] = 1'b0;
      din[i][k] = 8'h00;
    end
    rin[i] = 1'b1;
  endtask

  task automatic drive_full(input int i);
    for (int k = 0; k < 4; k++) begin
      if (xfer[i][k] || !vld[i][k]) din[i][k] = 8'($urandom);
      vld[i][k] = 1'b1;
    end
    rin[i] = 1'b1;
  endtask

  task automatic drive_random(input int i);
    for (int k = 0; k < 4; k++) begin
      if (xfer[i][k]) begin
        vld[i][k] = ($urandom_range(0, 99) < 85);
        din[i][k] = 8'($urandom);
      end else if (!vld[i][k]) begin
        vld[i][k] = ($urandom_range(0, 99) < 30);
        din[i][k] = 8'($urandom);
      end else if ($urandom_range(0, 99) < 5) begin
        vld[i][k] = 1'b0;
      end
    end
    rin[i] = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    int p;
    for (int i = 0; i < N; i++) begin
      drive_idle(i);
      for (int k = 0; k < 4; k++) xfer[i][k] = 1'b0;
    end

    // clock and reset
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) model_reset(i);
    cycle();
    check_eq("reset_data_out", 32'(dout[0]), 32'h0BC);
    check_eq("reset_valid_out", 32'(vout[0]), 32'h0);
    reset = 1'b0;

    // single requester on lane 2 with bytes 11..16
    p = 0;
    logging = 1'b1;
    for (int c = 0; c < 14; c++) begin
      vld[0][2] = (p < 6);
      din[0][2] = 8'h11 + 8'(p);
      cycle();
      if (xfer[0][2]) p++;
    end
    logging = 1'b0;
    check_eq("lane2_byte_count", 32'(log_q.size()), 32'd6);
    for (int j = 0; j < log_q.size() && j < 6; j++)
      check_eq($sformatf("lane2_byte%0d", j), 32'(log_q[j]), 32'(8'h11 + 8'(j)));
    drive_idle(0);

    // every lane valid after reset: grant order 0,1,2,3,0
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    gnt_log.delete();
    for (int i = 0; i < N; i++) drive_full(i);
    for (int c = 0; c < 40; c++) begin
      cycle();
      for (int i = 0; i < N; i++) drive_full(i);
    end
    check_eq("rr_grant_count", 32'(gnt_log.size() >= 5), 32'd1);
    for (int j = 0; j < gnt_log.size() && j < 5; j++)
      check_eq($sformatf("rr_grant%0d", j), 32'(gnt_log[j]), 32'(j % 4));

    // reset in the middle of a burst, then release with lanes 1 and 3 requesting
    reset = 1'b1;
    cycle();
    for (int k = 0; k < 4; k++) check_eq($sformatf("post_reset_ready%0d", k), 32'(rdy[0][k]), 32'd0);
    reset = 1'b0;
    drive_idle(0);
    vld[0][1] = 1'b1;
    vld[0][3] = 1'b1;
    cycle();
    check_eq("post_reset_grant", 32'(gnt[0]), 32'd1);

    // randomized traffic with backpressure, early release and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) drive_random(i);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
